ctr_sampler: RTL and testbench
==============================

CTR_SAMPLER -- requirements
Module: ctr_sampler

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, giving the counter value width in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer flop count (legal range 2..4).
REQ-003 The block SHALL have parameter MAX_TRIES, default 4, giving the maximum number of compare attempts before an error is flagged (legal range 1..15).
REQ-004 The block SHALL have port CLK_I, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port RST_ASYNC_NI, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port CNT_I, input, BIT_WIDTH bits: the free-running ripple-counter value, which is asynchronous to CLK_I and may be glitchy while bits ripple.
REQ-007 The block SHALL have port CAPTURE_I, input, 1 bit: a capture request that is sampled only in state IDLE.
REQ-008 The block SHALL have port READY_I, input, 1 bit: the consumer's acceptance of the result.
REQ-009 The block SHALL have port VALID_O, output, 1 bit: a result is available.
REQ-010 The block SHALL have port CNT_O, output, BIT_WIDTH bits: the captured stable count.
REQ-011 The block SHALL have port DELTA_O, output, BIT_WIDTH bits: the count increment since the previous accepted capture.
REQ-012 The block SHALL have port ERR_O, output, 1 bit: the capture was unstable; it is meaningful only while VALID_O=1.
REQ-013 The block SHALL have port BUSY_O, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 CNT_I SHALL pass through a free-running SYNC_STAGES-deep per-bit synchronizer; its output is sync_cnt.
REQ-015 The FSM SHALL have exactly four states: IDLE, SAMPLE, CHECK and HOLD.
REQ-016 IDLE: if CAPTURE_I=1, the FSM SHALL go to SAMPLE and clear the try counter; otherwise it SHALL stay in IDLE.
REQ-017 SAMPLE: the block SHALL load prev<=sync_cnt and go to CHECK.
REQ-018 CHECK, when sync_cnt==prev: the block SHALL set CNT_O<=prev, set DELTA_O<=prev-last (modulo 2^BIT_WIDTH), set last<=prev, set ERR_O<=0, and go to HOLD.
REQ-019 CHECK, when sync_cnt!=prev: the block SHALL load prev<=sync_cnt and increment tries; if tries reaches MAX_TRIES it SHALL set CNT_O<=sync_cnt, DELTA_O<=0, ERR_O<=1, leave last unchanged, and go to HOLD; otherwise it SHALL stay in CHECK.
REQ-020 HOLD: VALID_O SHALL be 1 and CNT_O, DELTA_O and ERR_O SHALL be stable; when READY_I=1 the FSM SHALL go to IDLE, with VALID_O=0 in the next cycle.
REQ-021 Latency SHALL be: CAPTURE_I high in cycle n (IDLE), stable input -> VALID_O high from cycle n+3; each mismatch SHALL add 1 cycle; worst case is n+2+MAX_TRIES.
REQ-022 CAPTURE_I SHALL be ignored in SAMPLE, CHECK and HOLD; no request is queued.
REQ-023 DELTA_O wrap-around SHALL follow these examples: last=16'hFFFE, new=16'h0003 -> DELTA_O=16'h0005; new==last -> DELTA_O=0.
REQ-024 When READY_I=1 in the same cycle HOLD is entered, the FSM SHALL still hold VALID_O for at least one cycle.
REQ-025 READY_I SHALL be ignored outside HOLD.
REQ-026 Outputs SHALL be driven only from registers, with no combinational path from CNT_I to any output.

Reset
REQ-027 When RST_ASYNC_NI=0, the block SHALL immediately force state=IDLE, VALID_O=0, ERR_O=0, BUSY_O=0, CNT_O=0, DELTA_O=0, last=0, prev=0, tries=0, and all synchronizer flops=0.
REQ-028 Reset asserted mid-capture or in HOLD SHALL discard the pending result; the first capture after reset SHALL report DELTA_O equal to CNT_O.
REQ-029 Reset deassertion SHALL take effect on the next CLK_I rising edge; no capture SHALL start in the same cycle as deassertion.

Structure
REQ-030 Package ctr_sampler_pkg SHALL hold the state enum (IDLE, SAMPLE, CHECK, HOLD) and the default constants for SYNC_STAGES and MAX_TRIES.
REQ-031 The synchronizer SHALL be a separate sub-module, bus_sync, with parameters WIDTH and STAGES and ports CLK_I, RST_ASYNC_NI, D_I and Q_O.
REQ-032 The FSM, datapath and subtractor SHALL reside in ctr_sampler itself.

Verification
REQ-033 Stable capture: CNT_I held at 16'h1234, CAPTURE_I pulsed at cycle 10 -> VALID_O=1 at cycle 13, CNT_O=16'h1234, DELTA_O=16'h1234, ERR_O=0.
REQ-034 Wrap delta: first capture at 16'hFFFE is accepted, then CNT_I=16'h0003 and a second capture is made -> DELTA_O=16'h0005, ERR_O=0.
REQ-035 Unstable input: CNT_I changes every cycle, MAX_TRIES=4 -> VALID_O=1 with ERR_O=1 and DELTA_O=0; the next stable capture's DELTA_O is computed against the last good value.
REQ-036 Backpressure: READY_I=0 for 20 cycles in HOLD while CNT_I changes -> outputs stay frozen and CAPTURE_I pulses are ignored; READY_I=1 -> IDLE next cycle.
REQ-037 Reset mid-operation: RST_ASYNC_NI pulsed low during CHECK -> all outputs 0 immediately; the next capture of 16'h0010 gives DELTA_O=16'h0010.
REQ-038 Back-to-back: READY_I tied to 1 and CAPTURE_I tied to 1 with CNT_I stable -> one result every 4 cycles, with VALID_O high for exactly 1 cycle each.

Source files
------------

// File: rtl/ctr_sampler_pkg.sv
// Shared types and default constants
// for the ripple-counter sampler.
package ctr_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CHECK,
    HOLD
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MAX_TRIES   = 4;
  localparam int TRY_W           = 4;

endpackage

// File: rtl/bus_sync.sv
// Per-bit multi-flop synchronizer for
// an asynchronous bus, reset to zero.
module bus_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             CLK_I,
  input  logic             RST_ASYNC_NI,
  input  logic [WIDTH-1:0] D_I,
  output logic [WIDTH-1:0] Q_O
);

  logic [WIDTH-1:0] pipe [STAGES];

  // free-running shift chain, one flop per bit per stage
  always_ff @(posedge CLK_I or negedge RST_ASYNC_NI) begin
    if (!RST_ASYNC_NI) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= D_I;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign Q_O = pipe[STAGES-1];

endmodule

// File: rtl/ctr_sampler.sv
// Samples a glitchy async ripple counter: waits for two
// equal synchronized reads, then reports count and delta.
module ctr_sampler
  import ctr_sampler_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MAX_TRIES   = DEF_MAX_TRIES
) (
  input  logic                 CLK_I,
  input  logic                 RST_ASYNC_NI,
  input  logic [BIT_WIDTH-1:0] CNT_I,
  input  logic                 CAPTURE_I,
  input  logic                 READY_I,
  output logic                 VALID_O,
  output logic [BIT_WIDTH-1:0] CNT_O,
  output logic [BIT_WIDTH-1:0] DELTA_O,
  output logic                 ERR_O,
  output logic                 BUSY_O
);

  localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

  state_t               state, state_n;
  logic [TRY_W-1:0]     tries, tries_n;
  logic [BIT_WIDTH-1:0] sync_cnt;
  logic [BIT_WIDTH-1:0] prev, last;
  logic [BIT_WIDTH-1:0] cnt_q, delta_q;
  logic                 err_q, valid_q, busy_q;
  logic                 match, give_up;

  bus_sync #(
    .WIDTH  (BIT_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK_I        (CLK_I),
    .RST_ASYNC_NI (RST_ASYNC_NI),
    .D_I          (CNT_I),
    .Q_O          (sync_cnt)
  );

  assign match = (sync_cnt == prev);

  // next-state and try-count decode
  always_comb begin
    state_n = state;
    tries_n = tries;
    give_up = 1'b0;
    unique case (state)
      IDLE: begin
        if (CAPTURE_I) begin
          state_n = SAMPLE;
          tries_n = '0;
        end
      end
      SAMPLE: state_n = CHECK;
      CHECK: begin
        if (match) begin
          state_n = HOLD;
        end else begin
          tries_n = tries + 1'b1;
          if (tries_n == MAX_T) begin
            give_up = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (READY_I) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, try counter and registered status flags
  always_ff @(posedge CLK_I or negedge RST_ASYNC_NI) begin
    if (!RST_ASYNC_NI) begin
      state   <= IDLE;
      tries   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      tries   <= tries_n;
      valid_q <= (state_n == HOLD);
      busy_q  <= (state_n != IDLE);
    end
  end

  // compare datapath and result registers
  always_ff @(posedge CLK_I or negedge RST_ASYNC_NI) begin
    if (!RST_ASYNC_NI) begin
      prev    <= '0;
      last    <= '0;
      cnt_q   <= '0;
      delta_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == SAMPLE) prev <= sync_cnt;
      if (state == CHECK) begin
        if (match) begin
          cnt_q   <= prev;
          delta_q <= prev - last;
          last    <= prev;
          err_q   <= 1'b0;
        end else begin
          prev <= sync_cnt;
          if (give_up) begin
            cnt_q   <= sync_cnt;
            delta_q <= '0;
            err_q   <= 1'b1;
          end
        end
      end
    end
  end

  assign VALID_O = valid_q;
  assign BUSY_O  = busy_q;
  assign CNT_O   = cnt_q;
  assign DELTA_O = delta_q;
  assign ERR_O   = err_q;

endmodule

// File: tb/tb_ctr_sampler.sv
// Directed bench for ctr_sampler: table of stable
// captures plus hand-written multi-cycle sequences.
module tb_ctr_sampler;

  logic        clk;
  logic        rst_n;
  logic [15:0] cnt_i;
  logic        capture_i;
  logic        ready_i;
  logic        valid_o;
  logic [15:0] cnt_o;
  logic [15:0] delta_o;
  logic        err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  ctr_sampler #(
    .BIT_WIDTH   (16),
    .SYNC_STAGES (2),
    .MAX_TRIES   (4)
  ) dut (
    .CLK_I        (clk),
    .RST_ASYNC_NI (rst_n),
    .CNT_I        (cnt_i),
    .CAPTURE_I    (capture_i),
    .READY_I      (ready_i),
    .VALID_O      (valid_o),
    .CNT_O        (cnt_o),
    .DELTA_O      (delta_o),
    .ERR_O        (err_o),
    .BUSY_O       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] exp_delta;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // stable value settles through the synchronizer, then one
  // capture pulse; lat counts cycles until VALID_O is seen
  task automatic capture(input logic [15:0] v, input bit spin,
                         output int lat);
    cnt_i = v;
    repeat (4) @(negedge clk);
    capture_i = 1'b1;
    if (spin) cnt_i = cnt_i + 16'd1;
    @(negedge clk);
    capture_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      if (spin) cnt_i = cnt_i + 16'd1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("valid_after_ready", 32'(valid_o), 32'd0);
    chk("busy_after_ready", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nvalid;
    int last_v;
    bit stable_ok;

    tbl[0] = '{16'h1234, 16'h1234};
    tbl[1] = '{16'hFFFE, 16'hEDCA};
    tbl[2] = '{16'h0003, 16'h0005};
    tbl[3] = '{16'h0003, 16'h0000};
    tbl[4] = '{16'h8000, 16'h7FFD};

    rst_n     = 1'b0;
    cnt_i     = 16'h0000;
    capture_i = 1'b0;
    ready_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_delta", 32'(delta_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      capture(tbl[i].cnt, 1'b0, lat);
      chk("tbl_latency", 32'(lat), 32'd3);
      chk("tbl_cnt", 32'(cnt_o), 32'(tbl[i].cnt));
      chk("tbl_delta", 32'(delta_o), 32'(tbl[i].exp_delta));
      chk("tbl_err", 32'(err_o), 32'd0);
      accept();
    end

    capture(16'h8000, 1'b1, lat);
    chk("unstable_latency", 32'(lat), 32'd6);
    chk("unstable_valid", 32'(valid_o), 32'd1);
    chk("unstable_err", 32'(err_o), 32'd1);
    chk("unstable_delta", 32'(delta_o), 32'd0);
    chk("unstable_cnt", 32'(cnt_o), 32'h8004);
    accept();

    capture(16'h9000, 1'b0, lat);
    chk("after_err_delta", 32'(delta_o), 32'h1000);
    chk("after_err_err", 32'(err_o), 32'd0);
    accept();

    capture(16'h9100, 1'b0, lat);
    chk("bp_delta", 32'(delta_o), 32'h0100);
    for (int i = 0; i < 20; i++) begin
      cnt_i     = cnt_i + 16'd3;
      capture_i = (i % 3 == 0);
      @(negedge clk);
      stable_ok = valid_o && !err_o && cnt_o == 16'h9100
                  && delta_o == 16'h0100 && busy_o;
      chk("bp_frozen", 32'(stable_ok), 32'd1);
    end
    capture_i = 1'b0;
    accept();
    repeat (3) @(negedge clk);
    chk("bp_no_queue", 32'(busy_o), 32'd0);

    cnt_i = 16'h0050;
    repeat (4) @(negedge clk);
    capture_i = 1'b1;
    cnt_i     = cnt_i + 16'd1;
    @(negedge clk);
    capture_i = 1'b0;
    cnt_i     = cnt_i + 16'd1;
    @(negedge clk);
    cnt_i     = cnt_i + 16'd1;
    chk("mid_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_o), 32'd0);
    chk("mid_rst_delta", 32'(delta_o), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    capture(16'h0010, 1'b0, lat);
    chk("post_rst_cnt", 32'(cnt_o), 32'h0010);
    chk("post_rst_delta", 32'(delta_o), 32'h0010);
    accept();

    ready_i   = 1'b1;
    capture_i = 1'b1;
    nvalid    = 0;
    last_v    = -1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (valid_o) begin
        nvalid++;
        if (last_v >= 0) chk("b2b_period", 32'(c - last_v), 32'd4);
        else chk("b2b_first", 32'(c), 32'd3);
        chk("b2b_delta", 32'(delta_o), 32'd0);
        chk("b2b_cnt", 32'(cnt_o), 32'h0010);
        last_v = c;
      end
    end
    capture_i = 1'b0;
    ready_i   = 1'b0;
    chk("b2b_count", 32'(nvalid), 32'd4);
    repeat (2) @(negedge clk);
    chk("b2b_idle", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
